// File: rtl/dmem_ctrl.sv
// dmem_ctrl: parametrised RV32I data memory with wait states,
// req/done handshake, post-reset clear and access error codes.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic [1:0]  err,
  output logic        init_busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW = IDX_W + 2;
  localparam logic [3:0] LP_WLAST =
    4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [IDX_W-1:0] LP_ILAST =
    IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic [3:0] r_cnt;
  logic r_we;
  logic [2:0] r_f3;
  logic [AW-1:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0] r_perr;
  logic [31:0] r_rdata;
  logic r_done;
  logic [1:0] r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic w_ill, w_mis, w_oor;
  logic [1:0] w_ierr;
  logic w_commit, w_idle;
  logic w_cwe;
  logic [2:0] w_cf3;
  logic [AW-1:0] w_caddr;
  logic [31:0] w_cwdata;
  logic [1:0] w_perr;
  logic [IDX_W-1:0] w_widx;
  logic [31:0] w_word, w_sword, w_load;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  // error classification of the request on the inputs
  always_comb begin
    w_ill = (funct3 == 3'b011) |
            (funct3[2:1] == 2'b11) |
            (we & funct3[2]);
    w_mis = ((funct3[1:0] == 2'b01) & addr[0]) |
            ((funct3[1:0] == 2'b10) & (|addr[1:0]));
    w_oor = |addr[31:AW];
    w_ierr = 2'b00;
    if (w_ill) w_ierr = 2'b11;
    else if (w_mis) w_ierr = 2'b01;
    else if (w_oor) w_ierr = 2'b10;
  end

  // next state; with zero wait states the access completes
  // straight from IDLE, so the live inputs stand in for the latch
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT: if (r_idx == LP_ILAST) w_next = S_IDLE;
      S_IDLE: if (req)
        w_next = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
      S_WAIT: if (r_cnt == LP_WLAST) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
    w_commit = (w_next == S_DONE);
    w_idle = (r_state == S_IDLE);
    w_cwe = w_idle ? we : r_we;
    w_cf3 = w_idle ? funct3 : r_f3;
    w_caddr = w_idle ? addr[AW-1:0] : r_addr;
    w_cwdata = w_idle ? wdata : r_wdata;
    w_perr = w_idle ? w_ierr : r_perr;
  end

  // lane extraction for loads and lane merge for stores
  always_comb begin
    w_widx = w_caddr[AW-1:2];
    w_word = r_mem[w_widx];
    w_byte = 8'(w_word >> {w_caddr[1:0], 3'b000});
    w_half = w_caddr[1] ? w_word[31:16] : w_word[15:0];
    w_load = 32'h0;
    unique case (w_cf3)
      3'b000: w_load = {{24{w_byte[7]}}, w_byte};
      3'b001: w_load = {{16{w_half[15]}}, w_half};
      3'b010: w_load = w_word;
      3'b100: w_load = {24'h0, w_byte};
      3'b101: w_load = {16'h0, w_half};
      default: w_load = 32'h0;
    endcase
    w_sword = w_word;
    unique case (w_cf3[1:0])
      2'b00: w_sword[{w_caddr[1:0], 3'b000} +: 8] = w_cwdata[7:0];
      2'b01: w_sword[{w_caddr[1], 4'b0000} +: 16] = w_cwdata[15:0];
      2'b10: w_sword = w_cwdata;
      default: w_sword = w_word;
    endcase
  end

  // control state, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_idx <= '0;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_f3 <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_perr <= '0;
      r_rdata <= '0;
      r_done <= 1'b0;
      r_err <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT) r_idx <= r_idx + 1'b1;
      if (r_state == S_WAIT) r_cnt <= r_cnt + 4'd1;
      if (w_idle && req) begin
        r_cnt <= '0;
        r_we <= we;
        r_f3 <= funct3;
        r_addr <= addr[AW-1:0];
        r_wdata <= wdata;
        r_perr <= w_ierr;
      end
      r_done <= w_commit;
      r_err <= w_commit ? w_perr : 2'b00;
      if (w_commit) begin
        if (w_perr != 2'b00) r_rdata <= 32'h0;
        else if (!w_cwe) r_rdata <= w_load;
      end
    end
  end

  // storage: sequential clear after reset, then store commits
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == S_INIT)
        r_mem[r_idx] <= 32'h0;
      else if (w_commit && w_cwe && w_perr == 2'b00)
        r_mem[w_widx] <= w_sword;
    end
  end

  assign rdata = r_rdata;
  assign done = r_done;
  assign err = r_err;
  assign stall = req & ~r_done;
  assign init_busy = (r_state == S_INIT);

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl with
// WAIT_STATES=0 (index 0) and WAIT_STATES=1 (index 1).
module tb_dmem_ctrl;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0] req, we, done, stall, busy;
  logic [2:0] f3 [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0] err [2];

  dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .req(req[0]), .we(we[0]),
    .funct3(f3[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .done(done[0]), .stall(stall[0]),
    .err(err[0]), .init_busy(busy[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .req(req[1]), .we(we[1]),
    .funct3(f3[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .done(done[1]), .stall(stall[1]),
    .err(err[1]), .init_busy(busy[1])
  );

  typedef struct packed {
    logic [31:0] rd;
    logic [1:0] er;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] last [2];
  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done[0]) begin
      if (q0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done0: got done=1, want 0");
      end else begin
        e = q0.pop_front();
        chk("rdata0", rdata[0], e.rd);
        chk("err0", 32'(err[0]), 32'(e.er));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done[1]) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done1: got done=1, want 0");
      end else begin
        e = q1.pop_front();
        chk("rdata1", rdata[1], e.rd);
        chk("err1", 32'(err[1]), 32'(e.er));
      end
    end
  end

  task automatic acc(input int d, input logic w,
                     input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] lv,
                     input logic [1:0] e);
    exp_t x;
    int n;
    x.er = e;
    x.rd = (e != 2'b00) ? 32'h0 : (w ? last[d] : lv);
    last[d] = x.rd;
    if (d == 0) q0.push_back(x);
    else q1.push_back(x);
    req[d] = 1'b1;
    we[d] = w;
    f3[d] = f;
    addr[d] = a;
    wdata[d] = wd;
    #1 chk("stall_accept", 32'(stall[d]), 1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!done[d]) chk("stall_wait", 32'(stall[d]), 1);
    end while (!done[d] && n < 20);
    chk("latency", n, d + 1);
    chk("stall_done", 32'(stall[d]), 0);
    req[d] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic init_len(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy[1] && n < 200);
    chk(nm, n, 64);
  endtask

  initial begin
    int n;
    exp_t x;
    rst_n = 1'b0;
    req = '0;
    we = '0;
    for (int i = 0; i < 2; i++) begin
      f3[i] = 3'b0;
      addr[i] = 32'h0;
      wdata[i] = 32'h0;
      last[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy[1]), 1);
    chk("rst_done", 32'(done[1]), 0);
    chk("rst_err", 32'(err[1]), 0);
    chk("rst_rdata", rdata[1], 0);
    rst_n = 1'b1;
    init_len("init_len");
    chk("init_len0", 32'(busy[0]), 0);

    acc(1, 0, LW, 32'h0FC, 0, 32'h0, 0);
    acc(1, 1, SW, 32'h010, 32'hDEADBEEF, 0, 0);
    acc(1, 0, LW, 32'h010, 0, 32'hDEADBEEF, 0);
    acc(1, 1, SW, 32'h010, 32'h11223344, 0, 0);
    acc(1, 1, SB, 32'h013, 32'h00000080, 0, 0);
    acc(1, 0, LB, 32'h013, 0, 32'hFFFFFF80, 0);
    acc(1, 0, LBU, 32'h013, 0, 32'h00000080, 0);
    acc(1, 0, LW, 32'h010, 0, 32'h80223344, 0);
    acc(1, 0, LH, 32'h012, 0, 32'hFFFF8022, 0);
    acc(1, 0, LHU, 32'h010, 0, 32'h00003344, 0);
    acc(1, 1, SH, 32'h012, 32'h1234ABCD, 0, 0);
    acc(1, 0, LW, 32'h010, 0, 32'hABCD3344, 0);

    acc(1, 0, LH, 32'h021, 0, 0, 2'b01);
    acc(1, 0, LW, 32'h100, 0, 0, 2'b10);
    acc(1, 1, 3'b110, 32'h010, 32'hFFFFFFFF, 0, 2'b11);
    acc(1, 1, 3'b100, 32'h010, 32'hFFFFFFFF, 0, 2'b11);
    acc(1, 1, SH, 32'h011, 32'hFFFFFFFF, 0, 2'b01);
    acc(1, 1, SW, 32'h104, 32'hFFFFFFFF, 0, 2'b10);
    acc(1, 0, 3'b011, 32'h001, 0, 0, 2'b11);
    acc(1, 0, LH, 32'h101, 0, 0, 2'b01);
    acc(1, 0, LW, 32'h010, 0, 32'hABCD3344, 0);
    acc(1, 0, LW, 32'h004, 0, 32'h00000000, 0);

    acc(0, 1, SW, 32'h000, 32'hA0A0A0A0, 0, 0);
    acc(0, 1, SW, 32'h004, 32'hB1B1B1B1, 0, 0);
    acc(0, 1, SW, 32'h008, 32'hC2C2C2C2, 0, 0);
    x.er = 2'b00;
    x.rd = 32'hA0A0A0A0;
    q0.push_back(x);
    x.rd = 32'hB1B1B1B1;
    q0.push_back(x);
    x.rd = 32'hC2C2C2C2;
    q0.push_back(x);
    last[0] = 32'hC2C2C2C2;
    req[0] = 1'b1;
    we[0] = 1'b0;
    f3[0] = LW;
    addr[0] = 32'h000;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!done[0] && n < 10);
      chk("b2b_latency", n, 1);
      if (k < 2) addr[0] = 32'(4 * (k + 1));
      else req[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b_gap", 32'(done[0]), 0);
    end

    acc(1, 1, SW, 32'h008, 32'h12345678, 0, 0);
    req[1] = 1'b1;
    we[1] = 1'b1;
    f3[1] = SW;
    addr[1] = 32'h008;
    wdata[1] = 32'h55AA55AA;
    @(posedge clk);
    #1;
    chk("abort_wait_done", 32'(done[1]), 0);
    rst_n = 1'b0;
    req[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort_done", 32'(done[1]), 0);
      chk("abort_busy", 32'(busy[1]), 1);
    end
    chk("abort_rdata", rdata[1], 0);
    last[0] = 32'h0;
    last[1] = 32'h0;
    rst_n = 1'b1;
    init_len("reinit_len");
    acc(1, 0, LW, 32'h008, 0, 32'h00000000, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(q0.size() + q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory controller that succeeds the fixed single-cycle dmem beside the riscvsingle core.
- Adds configurable depth and wait states, plus a req/done handshake that produces a core stall.
- Supports RV32I byte, halfword and word loads/stores, with sign or zero extension on loads.
- Clears memory automatically after reset and reports misaligned, out-of-range and illegal accesses.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words (power of two, 4..4096).
- WAIT_STATES, 1, extra cycles per access (0..15).
- IDX_W, $clog2(DEPTH_WORDS), word-index width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  1  access request; held with addr/we/funct3/wdata stable until done.
- we  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I size/sign code (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned.
- rdata  output  32  load result, extended; valid while done=1, held afterwards.
- done  output  1  one-cycle completion pulse.
- stall  output  1  combinational req & ~done; freezes the core PC.
- err  output  2  error code, valid with done: 00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- init_busy  output  1  high while the post-reset clear runs.

Behaviour:
- Reset is sampled on the rising edge of clk while reset=0.
- Reset values: state=INIT, clear index=0, rdata=0, done=0, err=00, init_busy=1.
- FSM states and transitions:
  - INIT: writes 0 to word[clear index], then increments the index. Lasts DEPTH_WORDS cycles, then goes to IDLE. req is ignored and stall follows req.
  - IDLE: if req=1, latches the request and goes to WAIT (WAIT_STATES>0) or DONE (WAIT_STATES=0). Otherwise stays in IDLE.
  - WAIT: counts WAIT_STATES cycles, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then returns to IDLE.
- Latency from accept edge to done: WAIT_STATES+1 cycles.
- Back-to-back requests: if req is still high in IDLE after DONE, it is a new request. There is no idle gap beyond the IDLE cycle.
- Error check is performed at accept. Priority is illegal (funct3 011/110/111, or a store with 1xx) > misaligned > range.
  - Misaligned: halfword access with addr[0]=1; word access with addr[1:0]!=0.
  - Out of range: addr[31:2] >= DEPTH_WORDS. The upper address bits are not aliased.
- Any error: no memory write, rdata=0, done still pulses, err carries the code for that done cycle only.
- Stores commit on the edge entering DONE:
  - SB writes wdata[7:0] to byte lane addr[1:0].
  - SH writes wdata[15:0] to lane addr[1].
  - SW writes all 32 bits.
  - Other bytes of the word are untouched.
- Loads are registered on the edge entering DONE:
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW returns the word.
- rdata holds its value until the next load completes. After a store, rdata is unchanged.
- err returns to 00 after done.
- Reset mid-operation (any state): the pending access is aborted with no write and no done; the FSM restarts INIT from index 0.
- Request inputs changing before done is a protocol violation; behaviour is undefined and there is no checker requirement.

Test Plan:
- Reset release, DEPTH_WORDS=64 -> init_busy=1 for exactly 64 cycles; a subsequent LW at 0x0FC returns 0x00000000.
- WAIT_STATES=1: SW 0xDEADBEEF to 0x010, then LW 0x010 -> each access has done 2 cycles after accept; stall is high in the accept and WAIT cycles; rdata=0xDEADBEEF.
- SB 0x80 to 0x013 over word 0x11223344 -> LB 0x013 gives 0xFFFFFF80, LBU gives 0x00000080, LW gives 0x80223344.
- LH 0x021 -> err=01, rdata=0; LW 0x100 with DEPTH_WORDS=64 -> err=10; SW with funct3=110 -> err=11; no memory word changes in any case.
- WAIT_STATES=0 with req held high for 3 LW accesses -> done is high every second cycle; each rdata matches its address.
- reset=0 asserted during WAIT of SW 0x55AA55AA to 0x008 -> no done; after the re-clear, LW 0x008 returns 0.
